// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, glyph patterns for the
// hex digits 0..F, the blank pattern and a pattern-to-hex decode helper.
package seg7_pkg;

  // Segment bit positions on the 7-bit drive bus (active high)
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [6:0] SEG_BLANK   = 7'h00;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG_GLYPH_F = 7'h71;

  typedef struct packed {
    logic       is_hex;
    logic [3:0] hex;
  } seg7_glyph_t;

  // Non-glyph patterns decode to is_hex=0, hex=0
  function automatic seg7_glyph_t seg7_decode(input logic [6:0] seg);
    seg7_glyph_t r;
    r.is_hex = 1'b1;
    r.hex    = 4'h0;
    case (seg)
      SEG_GLYPH_0: r.hex = 4'h0;
      SEG_GLYPH_1: r.hex = 4'h1;
      SEG_GLYPH_2: r.hex = 4'h2;
      SEG_GLYPH_3: r.hex = 4'h3;
      SEG_GLYPH_4: r.hex = 4'h4;
      SEG_GLYPH_5: r.hex = 4'h5;
      SEG_GLYPH_6: r.hex = 4'h6;
      SEG_GLYPH_7: r.hex = 4'h7;
      SEG_GLYPH_8: r.hex = 4'h8;
      SEG_GLYPH_9: r.hex = 4'h9;
      SEG_GLYPH_A: r.hex = 4'hA;
      SEG_GLYPH_B: r.hex = 4'hB;
      SEG_GLYPH_C: r.hex = 4'hC;
      SEG_GLYPH_D: r.hex = 4'hD;
      SEG_GLYPH_E: r.hex = 4'hE;
      SEG_GLYPH_F: r.hex = 4'hF;
      default:     r.is_hex = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Stability filter for the observed segment bus. A new pattern must be seen
// on STABLE_CYCLES+1 consecutive enabled edges and differ from the last
// accepted pattern before a one-cycle accept pulse is raised.
// Optional: SEG7_DEC_SYNC_EN inserts a 2-flop input synchronizer (+2 cycles).
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] seg_i,
  output logic       accept_o,
  output logic [6:0] pattern_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0] seg_s;

`ifdef SEG7_DEC_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  // Free-running two-flop synchronizer for pins from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= seg_i;
      sync2_q <= sync1_q;
    end
  end

  assign seg_s = sync2_q;
`else
  assign seg_s = seg_i;
`endif

  logic [6:0]       cand_q, cand_d;
  logic [6:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;

  assign match     = (seg_s == cand_q);
  assign accept_o  = ena && match && (cnt_q == CNT_LAST) && (cand_q != acc_q);
  assign pattern_o = cand_q;

  // Candidate tracking: restart on change, count up while stable, remember accepts
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (ena) begin
      if (!match) begin
        cand_d = seg_s;
        cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (accept_o) acc_d = cand_q;
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= SEG_BLANK;
      cnt_q  <= '0;
      acc_q  <= SEG_BLANK;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Decodes a 7-segment drive bus into frames (pattern, hex glyph, interval
// since previous frame) delivered on a valid/ready handshake with a sticky
// overrun flag when an unread frame is overwritten.
// Optional: SEG7_DEC_SYNC_EN (in seg7_stable_filter) adds an input synchronizer.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [6:0]          segments_in,
  input  logic                frame_ready,
  input  logic                clear_overrun,
  output logic                frame_valid,
  output logic [6:0]          frame_seg,
  output logic [3:0]          frame_hex,
  output logic                frame_is_hex,
  output logic [PERIOD_W-1:0] frame_period,
  output logic                overrun
);

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  logic        accept;
  logic [6:0]  pattern;
  seg7_glyph_t glyph;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .seg_i    (segments_in),
    .accept_o (accept),
    .pattern_o(pattern)
  );

  assign glyph = seg7_decode(pattern);

  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic                first_q, first_d;
  logic                valid_q, valid_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          hex_q, hex_d;
  logic                is_hex_q, is_hex_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                ovr_q, ovr_d;

  // Period counter, frame capture and output handshake
  always_comb begin
    pcnt_d   = pcnt_q;
    first_d  = first_q;
    valid_d  = valid_q;
    seg_d    = seg_q;
    hex_d    = hex_q;
    is_hex_d = is_hex_q;
    period_d = period_q;
    ovr_d    = ovr_q;

    if (ena) pcnt_d = sat_inc(pcnt_q);

    // Set has priority over clear; a same-cycle handshake is not an overwrite
    if (accept && valid_q && !frame_ready) ovr_d = 1'b1;
    else if (clear_overrun)                ovr_d = 1'b0;

    if (accept) begin
      seg_d    = pattern;
      hex_d    = glyph.hex;
      is_hex_d = glyph.is_hex;
      period_d = first_q ? '0 : sat_inc(pcnt_q);
      pcnt_d   = '0;
      first_d  = 1'b0;
      valid_d  = 1'b1;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      first_q  <= 1'b1;
      valid_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      hex_q    <= 4'h0;
      is_hex_q <= 1'b0;
      period_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      first_q  <= first_d;
      valid_q  <= valid_d;
      seg_q    <= seg_d;
      hex_q    <= hex_d;
      is_hex_q <= is_hex_d;
      period_q <= period_d;
      ovr_q    <= ovr_d;
    end
  end

  assign frame_valid  = valid_q;
  assign frame_seg    = seg_q;
  assign frame_hex    = hex_q;
  assign frame_is_hex = is_hex_q;
  assign frame_period = period_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: run-length based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seg7_frame_decoder;

  localparam int S    = 4;
  localparam int PW   = 8;
  localparam int PMAX = (1 << PW) - 1;
`ifdef SEG7_DEC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [6:0]    segments_in;
  logic          frame_ready;
  logic          clear_overrun;
  logic          frame_valid;
  logic [6:0]    frame_seg;
  logic [3:0]    frame_hex;
  logic          frame_is_hex;
  logic [PW-1:0] frame_period;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_frame_decoder #(
    .STABLE_CYCLES(S),
    .PERIOD_W     (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .segments_in  (segments_in),
    .frame_ready  (frame_ready),
    .clear_overrun(clear_overrun),
    .frame_valid  (frame_valid),
    .frame_seg    (frame_seg),
    .frame_hex    (frame_hex),
    .frame_is_hex (frame_is_hex),
    .frame_period (frame_period),
    .overrun      (overrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          m_valid, m_ishex, m_ovr, m_first, m_take;
  logic [6:0]    m_seg, m_acc, run_val, m_s, sy1, sy2;
  logic [3:0]    m_hex;
  logic [PW-1:0] m_period;
  int            run_len, en_edges, last_acc_edge, m_g, m_gap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_seg = 0; m_hex = 0; m_ishex = 0; m_period = 0; m_ovr = 0;
      run_val = 0; run_len = 1; m_acc = 0; m_first = 1;
      en_edges = 0; last_acc_edge = 0; sy1 = 0; sy2 = 0;
    end else begin
`ifdef SEG7_DEC_SYNC_EN
      m_s = sy2; sy2 = sy1; sy1 = segments_in;
`else
      m_s = segments_in;
`endif
      m_take = 0;
      if (ena) begin
        en_edges++;
        if (m_s != run_val) begin
          run_val = m_s;
          run_len = 1;
        end else if (run_len <= S) begin
          run_len++;
          m_take = (run_len == S + 1) && (run_val != m_acc);
        end
      end
      if (m_take && m_valid && !frame_ready) m_ovr = 1;
      else if (clear_overrun) m_ovr = 0;
      if (m_take) begin
        m_g = -1;
        for (int i = 0; i < 16; i++) if (glyph_tbl[i] == run_val) m_g = i;
        m_seg   = run_val;
        m_ishex = (m_g >= 0);
        m_hex   = (m_g >= 0) ? 4'(m_g) : 4'h0;
        m_gap   = en_edges - last_acc_edge;
        m_period = m_first ? '0 : ((m_gap > PMAX) ? PW'(PMAX) : PW'(m_gap));
        last_acc_edge = en_edges;
        m_first = 0;
        m_acc   = run_val;
        m_valid = 1;
      end else if (m_valid && frame_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_valid",   32'(frame_valid),  32'(m_valid));
    check("cyc_seg",     32'(frame_seg),    32'(m_seg));
    check("cyc_hex",     32'(frame_hex),    32'(m_hex));
    check("cyc_is_hex",  32'(frame_is_hex), 32'(m_ishex));
    check("cyc_period",  32'(frame_period), 32'(m_period));
    check("cyc_overrun", 32'(overrun),      32'(m_ovr));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_frame(input string nm, input logic [6:0] seg);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_valid && frame_seg == seg) found = 1;
    end
    check(nm, 32'(found), 32'd1);
  endtask

  task automatic first_latency(input string nm);
    int n = 0;
    @(negedge clk);
    segments_in = 7'h06;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!frame_valid && n < 40);
    check(nm, n, S + 1 + SYNC_LAT);
    check({nm, "_seg"},    32'(frame_seg),    32'h06);
    check({nm, "_hex"},    32'(frame_hex),    32'h1);
    check({nm, "_is_hex"}, 32'(frame_is_hex), 32'h1);
    check({nm, "_period"}, 32'(frame_period), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 0; ena = 1; segments_in = 7'h00; frame_ready = 1; clear_overrun = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Blank display for 100 cycles: no frame
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    check("idle_frames", seen, 0);
    check("idle_seg",     32'(frame_seg),    32'h0);
    check("idle_period",  32'(frame_period), 32'h0);
    check("idle_overrun", 32'(overrun),      32'h0);

    // First frame latency and contents
    first_latency("first");

    // Short glitch back to the accepted pattern yields nothing
    @(negedge clk);
    segments_in = 7'h5B;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    segments_in = 7'h06;
    repeat (10) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    check("glitch_frames", seen, 0);

    // 0x5B held 20 cycles, then 0x4F: interval 20
    segments_in = 7'h5B;
    repeat (20) @(negedge clk);
    segments_in = 7'h4F;
    wait_frame("wait_4f", 7'h4F);
    check("p20_period", 32'(frame_period), 32'd20);
    check("p20_hex",    32'(frame_hex),    32'h3);

    // Overwrite while consumer stalls
    @(negedge clk);
    frame_ready = 0;
    segments_in = 7'h66;
    repeat (8) @(negedge clk);
    segments_in = 7'h6D;
    repeat (8) @(negedge clk);
    check("ovr_valid", 32'(frame_valid), 32'h1);
    check("ovr_seg",   32'(frame_seg),   32'h6D);
    check("ovr_hex",   32'(frame_hex),   32'h5);
    check("ovr_flag",  32'(overrun),     32'h1);
    clear_overrun = 1;
    @(negedge clk);
    clear_overrun = 0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    frame_ready = 1;
    @(negedge clk);
    check("ovr_drained", 32'(frame_valid), 32'h0);

    // Non-glyph pattern
    segments_in = 7'h49;
    wait_frame("wait_49", 7'h49);
    check("nohex_is_hex", 32'(frame_is_hex), 32'h0);
    check("nohex_hex",    32'(frame_hex),    32'h0);

    // Interval beyond the counter range saturates
    repeat (300) @(negedge clk);
    segments_in = 7'h3F;
    wait_frame("wait_3f", 7'h3F);
    check("sat_period", 32'(frame_period), 32'hFF);
    check("sat_hex",    32'(frame_hex),    32'h0);
    check("sat_is_hex", 32'(frame_is_hex), 32'h1);

    // Enable paused mid-qualification
    segments_in = 7'h07;
    repeat (2) @(negedge clk);
    ena = 0;
    repeat (10) @(negedge clk);
    ena = 1;
    wait_frame("wait_07", 7'h07);

    // Reset while a frame is pending
    frame_ready = 0;
    @(negedge clk);
    segments_in = 7'h7F;
    wait_frame("wait_7f", 7'h7F);
    #3;
    rst_n = 0;
    #1;
    check("rst_valid",   32'(frame_valid),  32'h0);
    check("rst_seg",     32'(frame_seg),    32'h0);
    check("rst_hex",     32'(frame_hex),    32'h0);
    check("rst_is_hex",  32'(frame_is_hex), 32'h0);
    check("rst_period",  32'(frame_period), 32'h0);
    check("rst_overrun", 32'(overrun),      32'h0);
    segments_in = 7'h00;
    @(negedge clk);
    rst_n = 1;
    frame_ready = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    check("post_rst_frames", seen, 0);

    // First frame after reset: same latency, period 0
    first_latency("after_rst");
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
# seg7_frame_decoder

Observes a 7-segment drive bus such as the animation display output and decodes it back into discrete frames. Each accepted frame carries its raw pattern, its hex glyph value if it is one, and the clock-cycle interval since the previous frame. A pattern is accepted only after it has been stable for a minimum time. Frames are delivered over a valid/ready handshake. The block serves as an on-chip loopback monitor and as the reference checker for display animations in verification.

## Interface
- STABLE_CYCLES, 4: number of extra sampling edges a new pattern must hold before it is accepted; minimum 1.
- PERIOD_W, 24: width of the frame-interval counter; matches the 10 MHz second counter.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  when low, sampling, filtering and the period counter freeze; the output handshake keeps running.
- segments_in  in  7  observed segments; bit0=a … bit6=g, active high.
- frame_ready  in  1  consumer accepts the frame on `frame_valid & frame_ready`.
- clear_overrun  in  1  synchronous clear of `overrun`.
- frame_valid  out  1  frame available; reset 0.
- frame_seg  out  7  accepted pattern; reset 0.
- frame_hex  out  4  decoded glyph 0–F; 0 if the pattern is not a glyph; reset 0.
- frame_is_hex  out  1  pattern matches a hex glyph; reset 0.
- frame_period  out  PERIOD_W  cycles since the previous accepted frame; 0 for the first frame after reset; reset 0.
- overrun  out  1  sticky: a pending frame was overwritten; reset 0.

## Operation
- **Filter.** Registers `cand` (7 bits) and `cnt` (0..STABLE_CYCLES).
  - Input ≠ `cand`: load `cand`, set `cnt` = 0.
  - Input = `cand` and `cnt` < STABLE_CYCLES: increment `cnt`.
- **Accept condition.** Input = `cand`, `cnt` = STABLE_CYCLES-1, and `cand` ≠ `acc`, where `acc` is the last accepted pattern (reset 0x00).
  - A blank display after reset therefore yields no frame.
  - Re-asserting the same pattern yields no frame.
- **Period counter.** `pcnt` increments on each enabled cycle and saturates at all-ones. On accept: `frame_period` ← (`first` ? 0 : `pcnt` + 1, saturating); `pcnt` ← 0; `first` ← 0.
- **Glyph table.**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern: `frame_is_hex` = 0, `frame_hex` = 0.
- **Output register.** On accept, load `frame_seg`/`frame_hex`/`frame_is_hex`/`frame_period` and set `frame_valid` = 1.
  - `frame_valid & frame_ready` with no accept in that cycle: `frame_valid` ← 0.
  - Accept while `frame_valid & !frame_ready`: overwrite the output (latest wins) and set `overrun` = 1.
  - Accept in the same cycle as a handshake: load the new frame, `frame_valid` stays 1, no overrun.
- `clear_overrun` and an overwrite in the same cycle: `overrun` stays 1 (set wins).
- Reset mid-operation clears all state immediately. A pending frame is lost and no partial frame is emitted afterwards.

## Timing
- Edge 0 is the first edge at which a new pattern is sampled.
- The pattern must be present at edges 0..STABLE_CYCLES.
- `frame_valid` rises after edge STABLE_CYCLES.
- Add 2 cycles when the synchronizer is compiled in.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `frame_ready` may be held high continuously. Throughput is one frame per STABLE_CYCLES+1 cycles maximum.

## Configuration
- **SEG7_DEC_SYNC_EN defined:** `segments_in` passes through a 2-flop synchronizer (reset 0) before the filter, for observing external pins. Latency is +2 cycles.
- **Undefined:** the filter samples `segments_in` directly. This is for on-chip loopback in the same clock domain.

## Structure
- Package `seg7_pkg` holds:
  - the 16 glyph constants `SEG_GLYPH_0`..`SEG_GLYPH_F`;
  - `SEG_BLANK` = 7'h00;
  - the segment bit-order constants;
  - a glyph-to-hex decode function.
- Sub-module `seg7_stable_filter` contains the synchronizer option, `cand`/`cnt`/`acc`, and produces a one-cycle `accept` pulse plus the pattern.
- The top level contains the period counter, the glyph decode and the output handshake.

## Test plan
- Reset, hold 0x00 for 100 cycles → no `frame_valid`; all outputs 0.
- STABLE_CYCLES=4; drive 0x06 at edge 0 and hold → `frame_valid` after edge 4 with seg=06, hex=1, is_hex=1, period=0.
- Glitch: 0x5B for 2 cycles, then back to 0x06 → no frame. Then 0x5B held for 20 cycles before 0x4F → the 0x4F frame reports period=20.
- `frame_ready` = 0; accept 0x66 then 0x6D → output shows 6D, hex=5, `overrun` = 1. Assert `clear_overrun` → `overrun` = 0.
- Pattern 0x49 → is_hex=0, hex=0. Hold one pattern for more than 2^PERIOD_W cycles (PERIOD_W=8 in the bench) → the next frame reports period=255.
- Assert `rst_n` low while `frame_valid`=1 → all outputs are 0 immediately. With SEG7_DEC_SYNC_EN defined, the first frame after reset appears 2 cycles later than in the undefined case.
